// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    // Double-dabble correction applied before each shift.
    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit step: add-3 correction followed by a one-bit left shift.
module bcd_digit_cell
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    input  logic       carry_in,
    output bcd_digit_t digit_next,
    output logic       carry_out
);

    bcd_digit_t adj;

    assign adj        = add3(digit);
    assign digit_next = {adj[2:0], carry_in};
    assign carry_out  = adj[3];

endmodule

// File: rtl/bcd_seq_converter.sv
// Bit-serial binary-to-BCD converter (double dabble) with valid/ready on both sides.
// Optional BCD_EARLY_EXIT_EN skips leading zero bits of the magnitude.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 32,
    parameter int unsigned DIGITS = 10,
    parameter bit          SIGNED = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                out_neg,
    output logic                out_ovf
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    state_t             state;
    logic [BIN_W-1:0]   mag;
    logic [BCD_W-1:0]   digits;
    logic [BCD_W-1:0]   digits_next;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_acc;
    logic               neg_acc;
    logic [DIGITS:0]    carry;

    logic               neg_in;
    logic [BIN_W-1:0]   mag_in;
    logic [BIN_W-1:0]   mag_load;
    logic [CNT_W-1:0]   steps_in;

`ifdef BCD_EARLY_EXIT_EN
    logic [CNT_W-1:0]   lz;

    function automatic logic [CNT_W-1:0] lzc(input logic [BIN_W-1:0] v);
        logic [CNT_W-1:0] n;
        logic             found;
        n     = CNT_W'(BIN_W);
        found = 1'b0;
        for (int i = BIN_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = CNT_W'(BIN_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction
`endif

    // Magnitude and step count prepared for the accept cycle.
    always_comb begin
        neg_in = SIGNED && in_data[BIN_W-1];
        mag_in = neg_in ? BIN_W'(~in_data + BIN_W'(1)) : in_data;
`ifdef BCD_EARLY_EXIT_EN
        lz       = lzc(mag_in);
        mag_load = mag_in << lz;
        steps_in = (lz == CNT_W'(BIN_W)) ? CNT_W'(1) : CNT_W'(BIN_W) - lz;
`else
        mag_load = mag_in;
        steps_in = CNT_W'(BIN_W);
`endif
    end

    assign carry[0] = mag[BIN_W-1];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_cell u_cell (
            .digit      (digits[4*i +: 4]),
            .carry_in   (carry[i]),
            .digit_next (digits_next[4*i +: 4]),
            .carry_out  (carry[i+1])
        );
    end

    // Control FSM; the step after the last shift publishes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_neg   <= 1'b0;
            out_ovf   <= 1'b0;
            mag       <= '0;
            digits    <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            neg_acc   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        mag      <= mag_load;
                        digits   <= '0;
                        cnt      <= steps_in;
                        neg_acc  <= neg_in;
                        ovf_acc  <= 1'b0;
                        out_bcd  <= '0;
                        out_neg  <= 1'b0;
                        out_ovf  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        digits  <= digits_next;
                        mag     <= {mag[BIN_W-2:0], 1'b0};
                        cnt     <= cnt - CNT_W'(1);
                        ovf_acc <= ovf_acc | carry[DIGITS];
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_bcd   <= digits;
                        out_neg   <= neg_acc;
                        out_ovf   <= ovf_acc;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: unsigned, signed and 3-digit instances.
module tb_bcd_seq_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  in_valid = '0;
    logic [2:0]  out_ready = '0;
    logic [31:0] in_data [3];
    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  out_neg;
    wire  [2:0]  out_ovf;
    wire  [39:0] bcd0;
    wire  [39:0] bcd1;
    wire  [11:0] bcd2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_seq_converter #(.BIN_W(32), .DIGITS(10), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_bcd(bcd0), .out_neg(out_neg[0]), .out_ovf(out_ovf[0]));

    bcd_seq_converter #(.BIN_W(32), .DIGITS(10), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_bcd(bcd1), .out_neg(out_neg[1]), .out_ovf(out_ovf[1]));

    bcd_seq_converter #(.BIN_W(32), .DIGITS(3), .SIGNED(1'b0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_bcd(bcd2), .out_neg(out_neg[2]), .out_ovf(out_ovf[2]));

    // Expected accept-to-valid latency given the significant bits of the magnitude.
    function automatic int exp_lat(input int bits);
`ifdef BCD_EARLY_EXIT_EN
        return (bits == 0) ? 2 : bits + 1;
`else
        return 33;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] bcd_of(input int idx);
        case (idx)
            0:       return bcd0;
            1:       return bcd1;
            default: return {28'd0, bcd2};
        endcase
    endfunction

    task automatic wait_valid(input int idx, output int lat);
        lat = 0;
        while (!out_valid[idx] && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic convert(input int idx, input logic [31:0] d, output logic [39:0] bcd,
                           output logic neg, output logic ovf, output int lat);
        for (int i = 0; i < 10 && !in_ready[idx]; i++) tick();
        in_valid[idx] = 1'b1;
        in_data[idx]  = d;
        tick();
        in_valid[idx] = 1'b0;
        wait_valid(idx, lat);
        bcd = bcd_of(idx);
        neg = out_neg[idx];
        ovf = out_ovf[idx];
        out_ready[idx] = 1'b1;
        tick();
        out_ready[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 3'b111 || out_valid !== 3'b000) begin
            failures++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, need 111/000", in_ready, out_valid);
        end
        checks++;
        if (bcd0 !== 40'd0 || bcd1 !== 40'd0 || bcd2 !== 12'd0 || out_neg !== 3'b0 || out_ovf !== 3'b0) begin
            failures++;
            $display("FAIL reset_out: bcd0=%h bcd1=%h bcd2=%h neg=%b ovf=%b, need zeros",
                     bcd0, bcd1, bcd2, out_neg, out_ovf);
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] vin  [4] = '{32'd255, 32'd0, 32'hFFFFFFFF, 32'd7};
        logic [39:0] vexp [4] = '{40'h0000000255, 40'h0, 40'h4294967295, 40'h0000000007};
        int          vbits[4] = '{8, 0, 32, 3};
        logic [39:0] bcd;
        logic        neg, ovf;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            convert(0, vin[i], bcd, neg, ovf, lat);
            checks++;
            if (bcd !== vexp[i] || neg !== 1'b0 || ovf !== 1'b0) begin
                failures++;
                $display("FAIL uns_value[%0d]: got bcd=%h neg=%b ovf=%b, need %h/0/0", i, bcd, neg, ovf, vexp[i]);
            end
            checks++;
            if (lat !== exp_lat(vbits[i])) begin
                failures++;
                $display("FAIL uns_latency[%0d]: got %0d, need %0d", i, lat, exp_lat(vbits[i]));
            end
        end
    endtask

    task automatic test_signed();
        logic [31:0] vin  [4] = '{32'hFFFFFF85, 32'h80000000, 32'd42, 32'hFFFFFFFF};
        logic [39:0] vexp [4] = '{40'h0000000123, 40'h2147483648, 40'h0000000042, 40'h0000000001};
        logic        vneg [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        int          vbits[4] = '{7, 32, 6, 1};
        logic [39:0] bcd;
        logic        neg, ovf;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            convert(1, vin[i], bcd, neg, ovf, lat);
            checks++;
            if (bcd !== vexp[i] || neg !== vneg[i] || ovf !== 1'b0) begin
                failures++;
                $display("FAIL sgn_value[%0d]: got bcd=%h neg=%b ovf=%b, need %h/%b/0",
                         i, bcd, neg, ovf, vexp[i], vneg[i]);
            end
            checks++;
            if (lat !== exp_lat(vbits[i])) begin
                failures++;
                $display("FAIL sgn_latency[%0d]: got %0d, need %0d", i, lat, exp_lat(vbits[i]));
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] vin  [4] = '{32'd1000, 32'd999, 32'd1234, 32'd5};
        logic [11:0] vexp [4] = '{12'h000, 12'h999, 12'h234, 12'h005};
        logic        vovf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [39:0] bcd;
        logic        neg, ovf;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            convert(2, vin[i], bcd, neg, ovf, lat);
            checks++;
            if (bcd[11:0] !== vexp[i] || ovf !== vovf[i] || neg !== 1'b0) begin
                failures++;
                $display("FAIL ovf_value[%0d]: got bcd=%h ovf=%b neg=%b, need %h/%b/0",
                         i, bcd[11:0], ovf, neg, vexp[i], vovf[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        in_valid[0] = 1'b1;
        in_data[0]  = 32'd12345;
        tick();
        in_data[0]  = 32'd678;
        wait_valid(0, lat);
        checks++;
        if (lat !== exp_lat(14)) begin
            failures++;
            $display("FAIL bp_latency: got %0d, need %0d", lat, exp_lat(14));
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || bcd0 !== 40'h12345) begin
                failures++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b bcd=%h, need 1/0/12345",
                         i, out_valid[0], in_ready[0], bcd0);
            end
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_exit: valid=%b ready=%b, need 0/1", out_valid[0], in_ready[0]);
        end
        tick();
        in_valid[0] = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b0 || bcd0 !== 40'h0) begin
            failures++;
            $display("FAIL bp_accept: ready=%b bcd=%h, need 0/0", in_ready[0], bcd0);
        end
        wait_valid(0, lat);
        checks++;
        if (bcd0 !== 40'h678 || lat !== exp_lat(10)) begin
            failures++;
            $display("FAIL bp_second: bcd=%h lat=%0d, need 678/%0d", bcd0, lat, exp_lat(10));
        end
        out_ready[0] = 1'b1;
        tick();
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [39:0] bcd;
        logic        neg, ovf;
        int          lat;
        in_valid[0] = 1'b1;
        in_data[0]  = 32'd99999;
        tick();
        in_valid[0] = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || bcd0 !== 40'h0 || out_ovf[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_shift: valid=%b bcd=%h ovf=%b, need zeros", out_valid[0], bcd0, out_ovf[0]);
        end
        #3;
        rst_n = 1'b1;
        tick();
        in_valid[1] = 1'b1;
        in_data[1]  = 32'hFFFFFD09;
        tick();
        in_valid[1] = 1'b0;
        wait_valid(1, lat);
        checks++;
        if (out_valid[1] !== 1'b1 || bcd1 !== 40'h759 || out_neg[1] !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_done: valid=%b bcd=%h neg=%b, need 1/759/1", out_valid[1], bcd1, out_neg[1]);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[1] !== 1'b0 || bcd1 !== 40'h0 || out_neg[1] !== 1'b0) begin
            failures++;
            $display("FAIL rst_done: valid=%b bcd=%h neg=%b, need zeros", out_valid[1], bcd1, out_neg[1]);
        end
        #3;
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 3'b111 || out_valid !== 3'b000) begin
            failures++;
            $display("FAIL rst_release: in_ready=%b out_valid=%b, need 111/000", in_ready, out_valid);
        end
        convert(0, 32'd42, bcd, neg, ovf, lat);
        checks++;
        if (bcd !== 40'h42 || neg !== 1'b0 || ovf !== 1'b0 || lat !== exp_lat(6)) begin
            failures++;
            $display("FAIL rst_fresh: bcd=%h neg=%b ovf=%b lat=%0d, need 42/0/0/%0d", bcd, neg, ovf, lat, exp_lat(6));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
